// File: rtl/max7219_spi_rx.sv
// Receiver model of a daisy-chained MAX7219 array: oversamples sck/din/cs on clk,
// shifts frames in, and decodes each chip's 16-bit command into register state.
module max7219_spi_rx #(
    parameter int N_CHIPS     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sck,
    input  logic                   din,
    input  logic                   cs,
    output logic [64*N_CHIPS-1:0]  pixels,
    output logic [8*N_CHIPS-1:0]   decode_mode,
    output logic [4*N_CHIPS-1:0]   intensity,
    output logic [3*N_CHIPS-1:0]   scan_limit,
    output logic [N_CHIPS-1:0]     shutdown,
    output logic [N_CHIPS-1:0]     display_test,
    output logic                   frame_done,
    output logic                   frame_err
);
    localparam int FRAME_BITS = 16 * N_CHIPS;
    localparam int CW         = $clog2(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] sck_sync, din_sync, cs_sync;
    logic                   sck_d, cs_d;
    logic                   sck_s, din_s, cs_s;
    logic                   sck_rise, cs_rise, cs_fall;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CW-1:0]          bit_cnt;
    logic                   latch_q;
    logic [3:0]             addr [N_CHIPS];
    logic [7:0]             data [N_CHIPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            din_sync <= '0;
            cs_sync  <= '1;
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            din_sync <= {din_sync[SYNC_STAGES-2:0], din};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
        end
    end

    always_comb begin
        sck_s    = sck_sync[SYNC_STAGES-1];
        din_s    = din_sync[SYNC_STAGES-1];
        cs_s     = cs_sync[SYNC_STAGES-1];
        sck_rise = sck_s & ~sck_d;
        cs_rise  = cs_s & ~cs_d;
        cs_fall  = ~cs_s & cs_d;
    end

    // Gating on the delayed cs lets a bit arriving with the cs rise still shift;
    // the latch decision is taken a cycle later from the registered count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            latch_q <= 1'b0;
        end else begin
            latch_q <= cs_rise;
            if (cs_fall) begin
                bit_cnt <= '0;
            end else if (sck_rise && !cs_d) begin
                shreg <= (shreg << 1) | FRAME_BITS'(din_s);
                if (bit_cnt != CW'(FRAME_BITS))
                    bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_CHIPS; c++) begin
            addr[c] = shreg[c*16+8 +: 4];
            data[c] = shreg[c*16 +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixels       <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown     <= '1;
            display_test <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (latch_q) begin
                if (bit_cnt == CW'(FRAME_BITS)) begin
                    frame_done <= 1'b1;
                    for (int unsigned c = 0; c < N_CHIPS; c++) begin
                        case (addr[c])
                            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                                pixels[c*64 + (32'(addr[c]) - 32'd1)*8 +: 8] <= data[c];
                            4'h9: decode_mode[c*8 +: 8] <= data[c];
                            4'hA: intensity[c*4 +: 4]   <= data[c][3:0];
                            4'hB: scan_limit[c*3 +: 3]  <= data[c][2:0];
                            4'hC: shutdown[c]           <= ~data[c][0];
                            4'hF: display_test[c]       <= data[c][0];
                            default: ;
                        endcase
                    end
                end else if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end
endmodule
